// File: rtl/bram_frame_pkg.sv
// rtl/bram_frame_pkg.sv - shared types and constants for the frame BRAM sequencer
// Purpose: FSM state encoding, default frame geometry, BRAM read latency and
// the clogb2 helper used to size BRAM addresses.
// Ports: none (package).
package bram_frame_pkg;

  localparam int FRAME_RAM_WIDTH    = 8;
  localparam int FRAME_RAM_DEPTH    = 640 * 480;
  localparam int FRAME_READ_LATENCY = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Number of bits needed to represent 'depth' (0 for 0).
  function automatic int clogb2(input int depth);
    int d;
    int n;
    d = depth;
    n = 0;
    while (d > 0) begin
      n++;
      d = d >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// rtl/bram_rd_fifo.sv - small output FIFO absorbing BRAM read latency
// Purpose: DEPTH x WIDTH synchronous FIFO; head and count come straight from
// registers so the downstream stream is glitch-free.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous clear of all entries
//   push, push_data write one entry
//   pop             remove the head entry (ignored when empty)
//   head            current head entry
//   not_empty       head is valid
//   count           number of stored entries
module bram_rd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop && (count != '0);
  assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/bram_frame_ctrl.sv
// rtl/bram_frame_ctrl.sv - frame write/read sequencer for a dual-port frame BRAM
// Purpose: writes one frame from a valid/ready stream into port A, and on
// command scans port B and emits a backpressured pixel stream.
// Ports:
//   iClk, iRst_n                 clock, asynchronous active-low reset
//   iStartWr, iStartRd, iAbort   control pulses
//   iWrValid/oWrReady, iWrData   write pixel stream
//   oRdValid/iRdReady, oRdData, oRdLast  read pixel stream
//   oWrDone, oRdDone, oBusy      status
//   oEnA, oWeA, oAddrA, oDinA    BRAM port A (write)
//   oEnB, oRegceB, oAddrB, iDoutB  BRAM port B (read)
module bram_frame_ctrl
  import bram_frame_pkg::*;
#(
  parameter int RAM_WIDTH    = FRAME_RAM_WIDTH,
  parameter int RAM_DEPTH    = FRAME_RAM_DEPTH,
  parameter int ADDR_W       = clogb2(RAM_DEPTH - 1),
  parameter int READ_LATENCY = FRAME_READ_LATENCY,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iStartWr,
  input  logic                 iStartRd,
  input  logic                 iAbort,
  input  logic                 iWrValid,
  output logic                 oWrReady,
  input  logic [RAM_WIDTH-1:0] iWrData,
  output logic                 oRdValid,
  input  logic                 iRdReady,
  output logic [RAM_WIDTH-1:0] oRdData,
  output logic                 oRdLast,
  output logic                 oWrDone,
  output logic                 oRdDone,
  output logic                 oBusy,
  output logic                 oEnA,
  output logic                 oWeA,
  output logic [ADDR_W-1:0]    oAddrA,
  output logic [RAM_WIDTH-1:0] oDinA,
  output logic                 oEnB,
  output logic                 oRegceB,
  output logic [ADDR_W-1:0]    oAddrB,
  input  logic [RAM_WIDTH-1:0] iDoutB
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  state_t                    state;
  logic [ADDR_W-1:0]         wr_cnt;
  logic [ADDR_W-1:0]         rd_cnt;
  logic                      issue_last;   // travels with oEnB: address is the frame's last
  logic [READ_LATENCY-1:0]   vld_sr;       // marks cycles where iDoutB carries a requested pixel
  logic [READ_LATENCY-1:0]   lst_sr;
  logic [RAM_WIDTH:0]        fifo_head;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_push;
  logic                      pop;
  logic                      head_last;
  logic                      credit_ok;
  int                        inflight;

  assign oBusy     = (state != S_IDLE);
  assign oWrReady  = (state == S_WRITE);
  assign oRegceB   = (state == S_READ) || (state == S_DRAIN);
  assign oRdData   = fifo_head[RAM_WIDTH-1:0];
  assign oRdLast   = fifo_head[RAM_WIDTH];
  assign head_last = fifo_head[RAM_WIDTH];
  assign pop       = oRdValid && iRdReady;
  assign fifo_push = vld_sr[READ_LATENCY-1];

  // A new read may be issued only if every pixel already requested, plus this
  // one, is guaranteed a FIFO slot; the pop happening this edge frees one.
  always_comb begin
    inflight = int'(oEnB);
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + int'(vld_sr[i]);
    credit_ok = (int'(fifo_count) + inflight - int'(pop)) < FIFO_DEPTH;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= S_IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      oEnA       <= 1'b0;
      oWeA       <= 1'b0;
      oAddrA     <= '0;
      oDinA      <= '0;
      oEnB       <= 1'b0;
      oAddrB     <= '0;
      issue_last <= 1'b0;
      vld_sr     <= '0;
      lst_sr     <= '0;
      oWrDone    <= 1'b0;
      oRdDone    <= 1'b0;
    end else begin
      oEnA       <= 1'b0;
      oWeA       <= 1'b0;
      oEnB       <= 1'b0;
      issue_last <= 1'b0;
      oWrDone    <= 1'b0;
      oRdDone    <= 1'b0;
      vld_sr[0]  <= oEnB;
      lst_sr[0]  <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        lst_sr[i] <= lst_sr[i-1];
      end
      if (iAbort) begin
        state  <= S_IDLE;
        vld_sr <= '0;
        lst_sr <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (iStartWr) begin
              state  <= S_WRITE;
              wr_cnt <= '0;
            end else if (iStartRd) begin
              // Address 0 goes out on the start edge so the first pixel
              // is visible three cycles after the start pulse.
              state      <= (RAM_DEPTH == 1) ? S_DRAIN : S_READ;
              oEnB       <= 1'b1;
              oAddrB     <= '0;
              issue_last <= (RAM_DEPTH == 1);
              rd_cnt     <= ADDR_W'(1);
            end
          end
          S_WRITE: begin
            if (iWrValid) begin
              oEnA   <= 1'b1;
              oWeA   <= 1'b1;
              oAddrA <= wr_cnt;
              oDinA  <= iWrData;
              wr_cnt <= wr_cnt + 1'b1;
              if (wr_cnt == LAST_ADDR) begin
                state   <= S_IDLE;
                oWrDone <= 1'b1;
              end
            end
          end
          S_READ: begin
            if (credit_ok) begin
              oEnB   <= 1'b1;
              oAddrB <= rd_cnt;
              rd_cnt <= rd_cnt + 1'b1;
              if (rd_cnt == LAST_ADDR) begin
                issue_last <= 1'b1;
                state      <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            // The last-tagged pixel is the final one pushed, so its accept
            // implies nothing is left in flight or buffered.
            if (pop && head_last) begin
              state   <= S_IDLE;
              oRdDone <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  bram_rd_fifo #(
    .WIDTH(RAM_WIDTH + 1),
    .DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk      (iClk),
    .rst_n    (iRst_n),
    .flush    (iAbort),
    .push     (fifo_push),
    .push_data({lst_sr[READ_LATENCY-1], iDoutB}),
    .pop      (pop),
    .head     (fifo_head),
    .not_empty(oRdValid),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_bram_frame_ctrl.sv
// tb/tb_bram_frame_ctrl.sv - self-checking bench for bram_frame_ctrl
module tb_bram_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_wr, start_rd, abort_in;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       rd_last, wr_done, rd_done, busy;
  logic       en_a, we_a;
  logic [3:0] addr_a;
  logic [7:0] din_a;
  logic       en_b, regce_b;
  logic [3:0] addr_b;
  logic [7:0] dout_b = 8'h00;

  logic [7:0] mem [16];
  logic [7:0] b_stage = 8'h00;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_frame_ctrl #(.RAM_DEPTH(16)) dut (
    .iClk(clk), .iRst_n(rst_n),
    .iStartWr(start_wr), .iStartRd(start_rd), .iAbort(abort_in),
    .iWrValid(wr_valid), .oWrReady(wr_ready), .iWrData(wr_data),
    .oRdValid(rd_valid), .iRdReady(rd_ready), .oRdData(rd_data), .oRdLast(rd_last),
    .oWrDone(wr_done), .oRdDone(rd_done), .oBusy(busy),
    .oEnA(en_a), .oWeA(we_a), .oAddrA(addr_a), .oDinA(din_a),
    .oEnB(en_b), .oRegceB(regce_b), .oAddrB(addr_b), .iDoutB(dout_b)
  );

  // Behavioural 2-cycle BRAM: address register stage, then output register.
  always @(posedge clk) begin
    if (en_a && we_a) mem[addr_a] <= din_a;
    if (en_b) b_stage <= mem[addr_b];
    if (regce_b) dout_b <= b_stage;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       start_wr;
    logic       start_rd;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       exp_busy;
    logic       exp_wr_ready;
    logic       exp_en_a;
    logic [3:0] exp_addr_a;
    logic [7:0] exp_din_a;
    logic       exp_wr_done;
  } vec_t;

  function automatic vec_t mk(input logic sw, input logic sr, input logic wv, input logic [7:0] wd,
                              input logic eb, input logic er, input logic ea,
                              input logic [3:0] ad, input logic [7:0] di, input logic dn);
    vec_t v;
    v.start_wr = sw; v.start_rd = sr; v.wr_valid = wv; v.wr_data = wd;
    v.exp_busy = eb; v.exp_wr_ready = er; v.exp_en_a = ea;
    v.exp_addr_a = ad; v.exp_din_a = di; v.exp_wr_done = dn;
    return v;
  endfunction

  // Runs one read frame from a start pulse. mode 0: ready always high;
  // mode 1: ready one cycle in three, plus a 10-cycle hold-off mid-frame.
  task automatic read_frame(input int mode, input logic [7:0] base, input string tag);
    int n, first_v, last_c, done_c, done_n, max_cnt;
    logic prev_stall, ready;
    logic [7:0] prev_data;
    logic prev_last;
    n = 0; first_v = -1; last_c = -1; done_c = -1; done_n = 0; max_cnt = 0;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    rd_ready = (mode == 0);
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (rd_done) begin
        done_n++;
        done_c = c;
        check($sformatf("%s_busy_at_done", tag), busy, 1'b0);
      end
      if (prev_stall) begin
        check($sformatf("%s_stall_valid_c%0d", tag, c), rd_valid, 1'b1);
        check($sformatf("%s_stall_data_c%0d", tag, c), {rd_last, rd_data}, {prev_last, prev_data});
      end
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (mode == 0) ready = 1'b1;
      else ready = (c % 3 == 0) && !(c >= 20 && c < 30);
      rd_ready = ready;
      if (rd_valid && first_v < 0) first_v = c;
      if (rd_valid && ready) begin
        check($sformatf("%s_pix%0d", tag, n), rd_data, 8'(base + 8'(n)));
        check($sformatf("%s_last%0d", tag, n), rd_last, (n == 15));
        n++;
        last_c = c;
      end
      prev_stall = rd_valid && !ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
      if (done_n > 0 && c >= done_c + 3) break;
      tick();
    end
    check($sformatf("%s_pixel_count", tag), n, 16);
    check($sformatf("%s_done_count", tag), done_n, 1);
    check($sformatf("%s_done_after_last", tag), done_c, last_c + 1);
    check($sformatf("%s_fifo_bound", tag), max_cnt <= 4, 1'b1);
    if (mode == 0) begin
      check($sformatf("%s_first_valid_cycle", tag), first_v, 3);
      check($sformatf("%s_last_accept_cycle", tag), last_c, 18);
    end
    rd_ready = 1'b0;
  endtask

  vec_t vecs [18];

  initial begin
    int n_acc, bad_v, bad_d;
    rst_n = 1'b0; start_wr = 0; start_rd = 0; abort_in = 0;
    wr_valid = 0; wr_data = 8'h00; rd_ready = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Write frame with simultaneous starts and a start-read during WRITE.
    vecs[0] = mk(1, 1, 0, 8'h00, 1, 1, 0, 4'd0, 8'h00, 0);
    for (int j = 0; j < 16; j++)
      vecs[j+1] = mk(0, (j < 3), 1, 8'(8'hA0 + 8'(j)), (j != 15), (j != 15), 1,
                     4'(j), 8'(8'hA0 + 8'(j)), (j == 15));
    vecs[17] = mk(0, 0, 0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0);

    repeat (2) tick();
    check("reset_outputs",
          {busy, wr_ready, en_a, we_a, addr_a, din_a, en_b, regce_b, addr_b,
           rd_valid, rd_data, rd_last, wr_done, rd_done}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      start_wr = vecs[i].start_wr;
      start_rd = vecs[i].start_rd;
      wr_valid = vecs[i].wr_valid;
      wr_data  = vecs[i].wr_data;
      tick();
      check($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("v%0d_wr_ready", i), wr_ready, vecs[i].exp_wr_ready);
      check($sformatf("v%0d_en_we_a", i), {en_a, we_a}, {2{vecs[i].exp_en_a}});
      check($sformatf("v%0d_wr_done", i), wr_done, vecs[i].exp_wr_done);
      check($sformatf("v%0d_en_b", i), en_b, 1'b0);
      if (vecs[i].exp_en_a) begin
        check($sformatf("v%0d_addr_a", i), addr_a, vecs[i].exp_addr_a);
        check($sformatf("v%0d_din_a", i), din_a, vecs[i].exp_din_a);
      end
    end
    start_wr = 0; start_rd = 0; wr_valid = 0;
    for (int i = 0; i < 16; i++) check($sformatf("mem%0d", i), mem[i], 8'(8'hA0 + 8'(i)));

    read_frame(0, 8'hA0, "full");
    tick();
    read_frame(1, 8'hA0, "bp");
    tick();

    // Abort after five accepted pixels.
    rd_ready = 1'b1;
    start_rd = 1'b1;
    tick();
    start_rd = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 40 && n_acc < 5; c++) begin
      if (rd_valid) begin
        check($sformatf("abort_pix%0d", n_acc), rd_data, 8'(8'hA0 + 8'(n_acc)));
        n_acc++;
      end
      tick();
    end
    check("abort_pre_count", n_acc, 5);
    abort_in = 1'b1;
    rd_ready = 1'b0;
    tick();
    abort_in = 1'b0;
    check("abort_valid", rd_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    bad_v = 0; bad_d = 0;
    for (int c = 0; c < 6; c++) begin
      if (rd_valid) bad_v++;
      if (rd_done) bad_d++;
      tick();
    end
    check("abort_no_valid", bad_v, 0);
    check("abort_no_done", bad_d, 0);
    read_frame(0, 8'hA0, "restart");
    tick();

    // Asynchronous reset in the middle of a write frame.
    start_wr = 1'b1;
    tick();
    start_wr = 1'b0;
    wr_valid = 1'b1;
    for (int j = 0; j < 7; j++) begin
      wr_data = 8'(8'h50 + 8'(j));
      tick();
    end
    check("pre_reset_addr_a", addr_a, 4'd6);
    wr_data = 8'h57;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {busy, wr_ready, en_a, we_a, addr_a, din_a, wr_done, en_b}, 64'd0);
    #3 rst_n = 1'b1;
    wr_valid = 1'b0;
    tick();
    check("post_reset_busy", busy, 1'b0);
    start_wr = 1'b1;
    tick();
    start_wr = 1'b0;
    wr_valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      wr_data = 8'(8'h50 + 8'(j));
      tick();
      check($sformatf("rw%0d_addr_a", j), {en_a, addr_a}, {1'b1, 4'(j)});
    end
    wr_valid = 1'b0;
    tick();
    check("rw_mem0", mem[0], 8'h50);
    check("rw_mem7", mem[7], 8'h57);
    check("rw_mem15", mem[15], 8'h5F);
    read_frame(0, 8'h50, "reread");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_frame_ctrl.md
# bram_frame_ctrl

Sequencer for the 640x480 8-bit dual-port frame BRAM (`Bram_interface`, HIGH_PERFORMANCE mode).
- **Write side:** accepts one full frame of pixels through a valid/ready stream and writes it to BRAM port A.
- **Read side:** on command, scans port B from address 0 to RAM_DEPTH-1 and emits a backpressured pixel stream.
- **Latency handling:** absorbs the 2-cycle read latency with a credit-controlled output FIFO.
- **Placement:** sits between the capture/processing pipeline and the frame BRAM, and is the only master of both BRAM ports.

## Interface
Parameters:
- RAM_WIDTH, 8: pixel width in bits.
- RAM_DEPTH, 307200: pixels per frame (640*480).
- ADDR_W, clogb2(RAM_DEPTH-1) = 19: BRAM address width.
- READ_LATENCY, 2: cycles from port-B address to valid `iDoutB`.
- FIFO_DEPTH, 4: output buffer entries; must be >= READ_LATENCY+2.

Ports:
- iClk  in  1  single clock for the controller and both BRAM ports.
- iRst_n  in  1  reset; asynchronous, active-low.
- iStartWr  in  1  one-cycle pulse; begin frame write (IDLE only).
- iStartRd  in  1  one-cycle pulse; begin frame read (IDLE only).
- iAbort  in  1  synchronous abort to IDLE.
- iWrValid / oWrReady  in/out  1/1  write stream handshake.
- iWrData  in  RAM_WIDTH  write pixel.
- oRdValid / iRdReady  out/in  1/1  read stream handshake.
- oRdData  out  RAM_WIDTH  read pixel.
- oRdLast  out  1  high with the pixel from address RAM_DEPTH-1.
- oWrDone, oRdDone  out  1  one-cycle completion pulses.
- oBusy  out  1  state != IDLE.
- oEnA, oWeA  out  1  port A enable and write enable.
- oAddrA  out  ADDR_W  port A address.
- oDinA  out  RAM_WIDTH  port A write data.
- oEnB, oRegceB  out  1  port B enable and output-register enable.
- oAddrB  out  ADDR_W  port B address.
- iDoutB  in  RAM_WIDTH  port B read data.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN.
- **Reset:** state IDLE; all outputs 0; counters 0; FIFO empty.
- **IDLE:**
  - iStartWr -> WRITE, wr_cnt=0.
  - Else iStartRd -> READ, rd_cnt=0. iStartWr wins when both pulse together.
  - Start pulses outside IDLE are ignored.
- **WRITE:**
  - oWrReady=1.
  - Each beat (iWrValid & oWrReady) drives oEnA=oWeA=1, oAddrA=wr_cnt, oDinA=iWrData, registered, then wr_cnt++.
  - The beat at wr_cnt==RAM_DEPTH-1 -> IDLE; oWrDone pulses the cycle after that beat.
- **READ:**
  - Issue a port-B read (oEnB=1, oAddrB=rd_cnt, rd_cnt++) only when fifo_count + inflight < FIFO_DEPTH.
  - oRegceB=1 throughout READ and DRAIN.
  - A READ_LATENCY-deep valid shift register tags returning `iDoutB` for the FIFO push.
  - After issuing address RAM_DEPTH-1 -> DRAIN.
- **DRAIN:** stays until inflight==0 and the FIFO is empty. On the last pixel's accept -> IDLE, with oRdDone pulsing the next cycle.
- **Output stream:**
  - oRdValid = FIFO not empty; oRdData = FIFO head.
  - oRdLast is carried as a FIFO tag bit.
  - Once oRdValid is high, oRdData/oRdLast hold stable until accepted.
- **Abort:** iAbort in any state -> IDLE next cycle.
  - FIFO and inflight are flushed; BRAM returns still in flight are discarded.
  - No done pulse; oWrReady and oRdValid drop the next cycle.
- **Reset mid-operation:** identical to abort, but immediate and asynchronous.
- **Wrap-around:** counters never wrap; a frame always ends at RAM_DEPTH-1.

## Timing
- **Write path:** port-A signals are registered; the BRAM write occurs 1 cycle after the accepted beat.
- **Write throughput:** 1 pixel/cycle.
- **Read latency:**
  - Address issued at cycle t; `iDoutB` is pushed at t+READ_LATENCY.
  - oRdValid is earliest at t+READ_LATENCY+1 (FIFO registered output).
  - First pixel appears 3 cycles after iStartRd is sampled.
- **Read throughput:** with iRdReady held high, sustained 1 pixel/cycle with no bubbles after the first.
- **Frame duration:**
  - Write frame: RAM_DEPTH accepted beats.
  - Read frame: RAM_DEPTH + 3 cycles minimum from iStartRd to oRdDone-1.
- **Backpressure:**
  - iRdReady low for N cycles stalls issue within 1 cycle.
  - FIFO never overflows (credit rule); no pixel is dropped or duplicated.
- **Done pulses:** oWrDone and oRdDone are exactly 1 cycle and coincide with oBusy falling.

## Structure
- **Package `bram_frame_pkg`:**
  - state enum (IDLE/WRITE/READ/DRAIN).
  - RAM_WIDTH/RAM_DEPTH defaults.
  - READ_LATENCY.
  - clogb2 function.
- **Sub-module `bram_rd_fifo`:**
  - FIFO_DEPTH x (RAM_WIDTH+1) synchronous FIFO with count output.
  - Registered head; same iClk/iRst_n.
- **Top:** FSM, counters, inflight shift register and port drive.

## Test plan
Bench runs with RAM_DEPTH=16 and a behavioural 2-cycle BRAM model.
- **Write:** iStartWr, then 16 beats with data=0xA0+i -> BRAM holds 0xA0..0xAF; oWrDone exactly once, 16 cycles after the first beat with no gaps.
- **Full-rate read:** iStartRd with iRdReady=1 -> oRdValid first at +3 cycles; 16 consecutive pixels 0xA0..0xAF; oRdLast on 0xAF; oRdDone one cycle later.
- **Backpressure:** iRdReady toggles 1-of-3 and is held low 10 cycles mid-frame -> same 16-value sequence, no loss or duplicates; FIFO count never exceeds 4; oRdValid data stable while stalled.
- **Simultaneous starts:** iStartWr and iStartRd in the same cycle -> WRITE entered; iStartRd during WRITE is ignored (no read issued).
- **Abort:** iAbort after 5 read pixels -> oRdValid=0 and oBusy=0 next cycle; no oRdDone; a new iStartRd restarts at address 0 (0xA0).
- **Async reset:** iRst_n asserted during WRITE at wr_cnt=7 -> all outputs 0 immediately; after release, a new write starts at address 0.
